// File: rtl/bus_arbiter_pkg.sv
// Shared types, idle-bus constant and round-robin search helper for the bus arbiter.
package bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;
  localparam int RR_MAX     = 8;
  localparam int RR_IDX_W   = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  asn;
    logic                  rw;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_master_t;

  localparam bus_master_t BUS_IDLE = '{asn: 1'b1, rw: 1'b1, addr: '0, wdata: '0};

  typedef struct packed {
    logic                vld;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First active-low requester strictly after 'last', wrapping within 'num' masters.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   reqn,
                                       input logic [RR_IDX_W-1:0] last,
                                       input int unsigned         num);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      cand = (32'(last) + i) % num;
      if (i <= num && !res.vld && !reqn[cand[RR_IDX_W-1:0]]) begin
        res.vld = 1'b1;
        res.idx = cand[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_master_mux.sv
// Owner-select mux onto the shared bus; drives the idle-bus values when nobody owns it.
module bus_master_mux
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] m_asn,
  input  logic [NUM_MASTERS-1:0] m_rw,
  input  logic [BUS_ADDR_W-1:0]  m_addr  [NUM_MASTERS],
  input  logic [BUS_DATA_W-1:0]  m_wdata [NUM_MASTERS],
  input  logic [IDX_W-1:0]       owner,
  input  logic                   owner_vld,
  output bus_master_t            bus
);

  always_comb begin
    bus = BUS_IDLE;
    if (owner_vld) begin
      bus.asn   = m_asn[owner];
      bus.rw    = m_rw[owner];
      bus.addr  = m_addr[owner];
      bus.wdata = m_wdata[owner];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter: registered active-low grants plus owner-steered bus mux.
//
// state     | meaning
// ARB_IDLE  | no grant; first requester after 'last' is granted next cycle
// ARB_OWNED | owner holds the bus until it releases; handover is gapless
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int ADDR_W      = BUS_ADDR_W,
  parameter  int DATA_W      = BUS_DATA_W,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [NUM_MASTERS-1:0] m_reqn,
  output logic [NUM_MASTERS-1:0] m_grntn,
  input  logic [NUM_MASTERS-1:0] m_asn,
  input  logic [NUM_MASTERS-1:0] m_rw,
  input  logic [ADDR_W-1:0]      m_addr  [NUM_MASTERS],
  input  logic [DATA_W-1:0]      m_wdata [NUM_MASTERS],
  output logic                   s_asn,
  output logic                   s_rw,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wdata,
  output logic [IDX_W-1:0]       owner,
  output logic                   owner_vld
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_MASTERS-1:0] grntn_q, grntn_d;
  logic [RR_MAX-1:0]      reqn_ext;
  rr_pick_t               pick;
  bus_master_t            bus;

  always_comb begin
    reqn_ext = '1;
    reqn_ext[NUM_MASTERS-1:0] = m_reqn;
    // While owned, last_q equals owner_q, so this searches from owner+1.
    pick = rr_pick(reqn_ext, RR_IDX_W'(last_q), NUM_MASTERS);

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grntn_d = grntn_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick.vld) begin
          state_d = ARB_OWNED;
          owner_d = IDX_W'(pick.idx);
          last_d  = IDX_W'(pick.idx);
          grntn_d = ~(NUM_MASTERS'(1) << pick.idx);
        end
      end
      ARB_OWNED: begin
        if (m_reqn[owner_q]) begin
          if (pick.vld) begin
            owner_d = IDX_W'(pick.idx);
            last_d  = IDX_W'(pick.idx);
            grntn_d = ~(NUM_MASTERS'(1) << pick.idx);
          end else begin
            state_d = ARB_IDLE;
            grntn_d = '1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grntn_d = '1;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      grntn_q <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grntn_q <= grntn_d;
    end
  end

  assign m_grntn   = grntn_q;
  assign owner     = owner_q;
  assign owner_vld = (state_q == ARB_OWNED);

  bus_master_mux #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_mux (
    .m_asn    (m_asn),
    .m_rw     (m_rw),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .owner    (owner_q),
    .owner_vld(owner_vld),
    .bus      (bus)
  );

  assign s_asn   = bus.asn;
  assign s_rw    = bus.rw;
  assign s_addr  = bus.addr;
  assign s_wdata = bus.wdata;

endmodule
